// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the fetch stage (instruction reads) and the request unit
// (data reads/writes). Data has priority. A streak counter forces an instruction grant after
// DSTREAK consecutive data grants made while an instruction fetch was waiting.
// Optional build macro: ARB_PERF_EN adds free-running stall counters perf_istall/perf_dstall.
module memory_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          ihit,
  output logic          dhit,
  output logic [DW-1:0] iload,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ramRDY
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_istall,
  output logic [31:0]   perf_dstall
`endif
);

  typedef enum logic [1:0] {StIdle, StData, StInstr} state_e;

  localparam logic [3:0] StreakMax = 4'(DSTREAK);

  state_e        state_q, state_d;
  logic [3:0]    streak_q, streak_d;
  logic          lat_wen_q, lat_wen_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_store_q, lat_store_d;
  logic          dreq;

  assign dreq = dREN | dWEN;

  // Next-state: arbitrate in IDLE and latch the winning request; wait for ramRDY otherwise.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    lat_wen_d   = lat_wen_q;
    lat_addr_d  = lat_addr_q;
    lat_store_d = lat_store_q;
    unique case (state_q)
      StIdle: begin
        if (dreq && !(iREN && (streak_q == StreakMax))) begin
          state_d     = StData;
          lat_wen_d   = dWEN;  // read+write together is a write
          lat_addr_d  = daddr;
          lat_store_d = dstore;
          // Only data grants that bypass a waiting fetch extend the streak.
          if (!iREN) begin
            streak_d = 4'd0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (iREN) begin
          state_d     = StInstr;
          lat_wen_d   = 1'b0;
          lat_addr_d  = iaddr;
          lat_store_d = '0;
        end
      end
      StData: begin
        if (ramRDY) state_d = StIdle;
      end
      StInstr: begin
        if (ramRDY) begin
          state_d  = StIdle;
          streak_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers; async reset abandons any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      streak_q    <= 4'd0;
      lat_wen_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_store_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      lat_wen_q   <= lat_wen_d;
      lat_addr_q  <= lat_addr_d;
      lat_store_q <= lat_store_d;
    end
  end

  // RAM port is driven only from latched state; hits and load data follow ramRDY directly.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      StData: begin
        ramREN   = ~lat_wen_q;
        ramWEN   = lat_wen_q;
        ramaddr  = {lat_addr_q[AW-1:2], 2'b00};
        ramstore = lat_store_q;
        dhit     = ramRDY;
        if (ramRDY && !lat_wen_q) dload = ramload;
      end
      StInstr: begin
        ramREN  = 1'b1;
        ramaddr = {lat_addr_q[AW-1:2], 2'b00};
        ihit    = ramRDY;
        if (ramRDY) iload = ramload;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_EN
  // Stall counters: cycles a request is pending without completing; wrap on overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_istall <= '0;
      perf_dstall <= '0;
    end else begin
      if (iREN && !ihit) perf_istall <= perf_istall + 32'd1;
      if (dreq && !dhit) perf_dstall <= perf_dstall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written corner sequences
// (reset mid-access, starvation) and randomized stimulus against a transaction-level model.
module tb_memory_arbiter;

  localparam int DSTREAK = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ramRDY;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_PERF_EN
  logic [31:0] perf_istall, perf_dstall;
`endif

  memory_arbiter #(.AW(32), .DW(32), .DSTREAK(DSTREAK)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramRDY(ramRDY)
`ifdef ARB_PERF_EN
    , .perf_istall(perf_istall), .perf_dstall(perf_dstall)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          busy;
    bit          instr;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } txn_t;

  txn_t m_cur;
  int   m_bypass;   // data grants in a row that overtook a waiting fetch
  int   m_istall, m_dstall;

  logic        e_ihit, e_dhit, e_ren, e_wen;
  logic [31:0] e_addr, e_store, e_iload, e_dload;

  function automatic void model_reset();
    m_cur    = '{busy: 0, instr: 0, wr: 0, addr: '0, store: '0};
    m_bypass = 0;
    m_istall = 0;
    m_dstall = 0;
  endfunction

  function automatic void model_outputs();
    bit is_d;
    is_d    = m_cur.busy && !m_cur.instr;
    e_ren   = m_cur.busy && (m_cur.instr || !m_cur.wr);
    e_wen   = is_d && m_cur.wr;
    e_addr  = m_cur.busy ? (m_cur.addr & 32'hFFFF_FFFC) : 32'h0;
    e_store = is_d ? m_cur.store : 32'h0;
    e_ihit  = m_cur.busy && m_cur.instr && ramRDY;
    e_dhit  = is_d && ramRDY;
    e_iload = e_ihit ? ramload : 32'h0;
    e_dload = (e_dhit && !m_cur.wr) ? ramload : 32'h0;
  endfunction

  function automatic void model_step();
    if (iREN && !e_ihit) m_istall++;
    if ((dREN || dWEN) && !e_dhit) m_dstall++;
    if (!m_cur.busy) begin
      if ((dREN || dWEN) && !(iREN && m_bypass >= DSTREAK)) begin
        m_cur    = '{busy: 1, instr: 0, wr: dWEN, addr: daddr, store: dstore};
        m_bypass = iREN ? ((m_bypass < DSTREAK) ? m_bypass + 1 : DSTREAK) : 0;
      end else if (iREN) begin
        m_cur = '{busy: 1, instr: 1, wr: 0, addr: iaddr, store: '0};
      end
    end else if (ramRDY) begin
      if (m_cur.instr) m_bypass = 0;
      m_cur.busy = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    chk1({tag, ".ihit"}, ihit, e_ihit);
    chk1({tag, ".dhit"}, dhit, e_dhit);
    chk1({tag, ".ramREN"}, ramREN, e_ren);
    chk1({tag, ".ramWEN"}, ramWEN, e_wen);
    chk32({tag, ".ramaddr"}, ramaddr, e_addr);
    chk32({tag, ".ramstore"}, ramstore, e_store);
    chk32({tag, ".iload"}, iload, e_iload);
    chk32({tag, ".dload"}, dload, e_dload);
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramRDY = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iren;
    logic [31:0] ia;
    logic        dren, dwen;
    logic [31:0] da, ds;
    logic        rdy;
    logic [31:0] rl;
    logic        xi, xd, xren, xwen;
    logic [31:0] xaddr, xstore, xiload, xdload;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  initial begin
    nRST = 1'b0;
    clear_inputs();
    model_reset();

    // Reset state
    #3;
    chk1("reset.ramREN", ramREN, 1'b0);
    chk1("reset.ramWEN", ramWEN, 1'b0);
    chk1("reset.ihit", ihit, 1'b0);
    chk1("reset.dhit", dhit, 1'b0);
    chk32("reset.ramaddr", ramaddr, 32'h0);
    do_reset();

    //          iren ia        dren dwen da          ds            rdy rl
    //          xi xd xren xwen xaddr       xstore        xiload        xdload
    // instruction read with ramRDY on the 3rd grant cycle; ramRDY in IDLE ignored
    vt[0]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        1, 32'hDEADBEEF,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    vt[1]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 32'h0,
               0, 0, 1, 0, 32'h104,  32'h0,        32'h0,        32'h0};
    vt[2]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 32'h0,
               0, 0, 1, 0, 32'h104,  32'h0,        32'h0,        32'h0};
    vt[3]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        1, 32'hDEADBEEF,
               1, 0, 1, 0, 32'h104,  32'h0,        32'hDEADBEEF, 32'h0};
    vt[4]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h55,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    // simultaneous requests: data first (address aligned), bubble, then instruction
    vt[5]  = '{1, 32'h300, 1, 0, 32'h2002, 32'h0,        0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    vt[6]  = '{1, 32'h300, 1, 0, 32'h2002, 32'h0,        1, 32'h11111111,
               0, 1, 1, 0, 32'h2000, 32'h0,        32'h0,        32'h11111111};
    vt[7]  = '{1, 32'h300, 0, 0, 32'h0,    32'h0,        0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    vt[8]  = '{1, 32'h300, 0, 0, 32'h0,    32'h0,        1, 32'h22222222,
               1, 0, 1, 0, 32'h300,  32'h0,        32'h22222222, 32'h0};
    vt[9]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    // write; upstream address changes mid-access and must be ignored
    vt[10] = '{0, 32'h0,   0, 1, 32'h40,   32'h12345678, 0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    vt[11] = '{0, 32'h0,   0, 1, 32'h80,   32'h0,        0, 32'h0,
               0, 0, 0, 1, 32'h40,   32'h12345678, 32'h0,        32'h0};
    vt[12] = '{0, 32'h0,   0, 1, 32'h80,   32'h0,        1, 32'h99999999,
               0, 1, 0, 1, 32'h40,   32'h12345678, 32'h0,        32'h0};
    vt[13] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    // read+write together behaves as a write
    vt[14] = '{0, 32'h0,   1, 1, 32'h53,   32'hCAFE,     0, 32'h0,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};
    vt[15] = '{0, 32'h0,   1, 1, 32'h53,   32'hCAFE,     1, 32'h77,
               0, 1, 0, 1, 32'h50,   32'hCAFE,     32'h0,        32'h0};
    vt[16] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h77,
               0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        32'h0};

    for (int i = 0; i < NV; i++) begin
      @(posedge CLK);
      #1;
      iREN = vt[i].iren; iaddr = vt[i].ia; dREN = vt[i].dren; dWEN = vt[i].dwen;
      daddr = vt[i].da; dstore = vt[i].ds; ramRDY = vt[i].rdy; ramload = vt[i].rl;
      @(negedge CLK);
      e_ihit = vt[i].xi; e_dhit = vt[i].xd; e_ren = vt[i].xren; e_wen = vt[i].xwen;
      e_addr = vt[i].xaddr; e_store = vt[i].xstore; e_iload = vt[i].xiload;
      e_dload = vt[i].xdload;
      check_all($sformatf("vec%0d", i));
    end

    // ---------------- reset in the middle of a data access ----------------
    @(posedge CLK);
    #1;
    clear_inputs();
    dREN = 1; daddr = 32'h10;
    @(posedge CLK);
    #1;
    ramRDY = 1; ramload = 32'h77;
    #1;
    chk1("rst_mid.pre_dhit", dhit, 1'b1);
    nRST = 1'b0;
    #1;
    chk1("rst_mid.ramREN", ramREN, 1'b0);
    chk1("rst_mid.ramWEN", ramWEN, 1'b0);
    chk1("rst_mid.dhit", dhit, 1'b0);
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    ramRDY = 1;
    @(negedge CLK);
    chk1("rst_mid.idle_ramREN", ramREN, 1'b0);
    chk1("rst_mid.idle_dhit", dhit, 1'b0);
    chk1("rst_mid.idle_ihit", ihit, 1'b0);

    // ---------------- instruction starvation guard ----------------
    begin
      int  nd = 0;
      int  d_before_i = -1;
      bit  got_i = 0;
      @(posedge CLK);
      #1;
      iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h800; ramRDY = 1; ramload = 32'h5A5A;
      for (int c = 0; c < 60 && nd < 5; c++) begin
        @(negedge CLK);
        if (ihit && !got_i) begin
          got_i = 1;
          d_before_i = nd;
        end
        if (dhit) nd++;
        @(posedge CLK);
        #1;
        if (got_i) iREN = 0;
      end
      chk1("starve.ihit_seen", got_i, 1'b1);
      chk32("starve.dhits_before_ihit", d_before_i, 32'd4);
      chk32("starve.total_dhits", nd, 32'd5);
    end

`ifdef ARB_PERF_EN
    // ---------------- stall counter ----------------
    do_reset();
    @(posedge CLK);
    #1;
    iREN = 1; iaddr = 32'h20;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #1;
    ramRDY = 1; ramload = 32'h1;
    @(negedge CLK);
    chk1("perf.ihit", ihit, 1'b1);
    @(posedge CLK);
    #1;
    clear_inputs();
    @(negedge CLK);
    chk32("perf.istall", perf_istall, 32'd3);
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge CLK);
      #1;
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = ($urandom_range(0, 1) == 0);
      dWEN    = ($urandom_range(0, 3) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      ramRDY  = ($urandom_range(0, 1) == 0);
      @(negedge CLK);
      model_outputs();
      check_all($sformatf("rand%0d", c));
      chk1($sformatf("rand%0d.exclusive", c), ihit & dhit, 1'b0);
`ifdef ARB_PERF_EN
      chk32($sformatf("rand%0d.perf_istall", c), perf_istall, 32'(m_istall));
      chk32($sformatf("rand%0d.perf_dstall", c), perf_dstall, 32'(m_dstall));
`endif
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
